// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
// PISO_PARITY_EN (when defined) lengthens every frame by one even-parity bit.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_e;

   localparam int PISO_WIDTH_DEFAULT = 8;

   // Number of dout_vld cycles per accepted word.
   function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, one bit per clock, back-to-back capable.
// Build option: PISO_PARITY_EN appends an even-parity bit (^word) after the LSB.
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic             ready,
   output logic             dout,
   output logic             dout_vld,
   output logic             done
);

   localparam int                 FRAME_LEN = frame_len(WIDTH);
   localparam int                 CNT_W     = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(FRAME_LEN - 1);

   piso_state_e          state_q, state_d;
   logic [FRAME_LEN-1:0] sreg_q, sreg_d;
   logic [FRAME_LEN-1:0] frame_word;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 last_bit;
   logic                 accept;

   // The parity bit rides in the shift register below the LSB, so dout is always the MSB.
`ifdef PISO_PARITY_EN
   assign frame_word = {din, ^din};
`else
   assign frame_word = din;
`endif

   // Handshake: load is valid, ready is ready; a word is taken on a posedge with load && ready.
   // ready depends on registered state only, so no path exists from load/din to any output.
   assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
   assign ready    = (state_q == IDLE) || last_bit;
   assign accept   = load && ready;

   assign dout_vld = (state_q == SHIFT);
   assign dout     = (state_q == SHIFT) && sreg_q[FRAME_LEN-1];
   assign done     = last_bit;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = SHIFT;
         sreg_d  = frame_word;
         cnt_d   = '0;
      end else if (state_q == SHIFT) begin
         if (last_bit) begin
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
         end else begin
            sreg_d  = sreg_q << 1;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: expected bit stream built from each accepted word,
// plus a behavioural serial-in receiver on dout for the loopback check.
module tb_piso_tx;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         clr_n;
   logic         load;
   logic [W-1:0] din;
   logic         ready, dout, dout_vld, done;

   logic         exp_q[$];
   logic [W-1:0] rx_q;
   logic [W-1:0] rx_exp;
   int           n_chk = 0;
   int           n_pass = 0;

   piso_tx #(.WIDTH(W)) dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .din      (din),
      .load     (load),
      .ready    (ready),
      .dout     (dout),
      .dout_vld (dout_vld),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Serial-in receiver: shifts dout in at the LSB end on every valid bit.
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) rx_q <= '0;
      else if (dout_vld) rx_q <= {rx_q[W-2:0], dout};
   end

   function automatic void push_frame(input logic [W-1:0] w);
      for (int k = 0; k < W; k++) exp_q.push_back(w[W-1-k]);
`ifdef PISO_PARITY_EN
      exp_q.push_back(^w);
`endif
   endfunction

   task automatic test_reset();
      clr_n = 1'b1; load = 1'b0; din = '0;
      #3 clr_n = 1'b0;
      #1;
      n_chk++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else n_pass++;
      n_chk++; if (dout !== 1'b0) $display("FAIL reset_dout got=%b exp=0", dout); else n_pass++;
      n_chk++; if (dout_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", dout_vld); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      rx_exp = '0;
      exp_q.delete();
   endtask

   // One frame; optionally pulses load with poke_w at loop index poke_k (must be ignored).
   task automatic send_frame(input logic [W-1:0] w, input int poke_k,
                             input logic [W-1:0] poke_w, input string tag);
      logic b, last;
      @(negedge clk);
      n_chk++; if (ready !== 1'b1) $display("FAIL %s ready_at_accept got=%b exp=1", tag, ready); else n_pass++;
      load = 1'b1; din = w;
      push_frame(w);
      for (int k = 0; k < FL; k++) begin
         @(negedge clk);
         b = exp_q.pop_front();
         rx_exp = {rx_exp[W-2:0], b};
         last = (k == FL - 1);
         n_chk++; if (dout_vld !== 1'b1) $display("FAIL %s vld k=%0d got=%b exp=1", tag, k, dout_vld); else n_pass++;
         n_chk++; if (dout !== b) $display("FAIL %s dout k=%0d got=%b exp=%b", tag, k, dout, b); else n_pass++;
         n_chk++; if (done !== last) $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done, last); else n_pass++;
         n_chk++; if (ready !== last) $display("FAIL %s ready k=%0d got=%b exp=%b", tag, k, ready, last); else n_pass++;
         load = 1'b0; din = W'($urandom);
         if (k == poke_k) begin load = 1'b1; din = poke_w; end
      end
      @(negedge clk);
      n_chk++; if (dout_vld !== 1'b0) $display("FAIL %s idle_vld got=%b exp=0", tag, dout_vld); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL %s idle_done got=%b exp=0", tag, done); else n_pass++;
      n_chk++; if (ready !== 1'b1) $display("FAIL %s idle_ready got=%b exp=1", tag, ready); else n_pass++;
      n_chk++; if (rx_q !== rx_exp) $display("FAIL %s loopback got=%h exp=%h", tag, rx_q, rx_exp); else n_pass++;
   endtask

   // Two words with load held high throughout; the second is taken in the done cycle.
   task automatic test_back_to_back(input logic [W-1:0] w1, input logic [W-1:0] w2, input string tag);
      logic b, last;
      @(negedge clk);
      n_chk++; if (ready !== 1'b1) $display("FAIL %s ready_at_accept got=%b exp=1", tag, ready); else n_pass++;
      load = 1'b1; din = w1;
      push_frame(w1);
      push_frame(w2);
      for (int k = 0; k < 2 * FL; k++) begin
         @(negedge clk);
         b = exp_q.pop_front();
         rx_exp = {rx_exp[W-2:0], b};
         last = (k == FL - 1) || (k == 2 * FL - 1);
         n_chk++; if (dout_vld !== 1'b1) $display("FAIL %s vld k=%0d got=%b exp=1", tag, k, dout_vld); else n_pass++;
         n_chk++; if (dout !== b) $display("FAIL %s dout k=%0d got=%b exp=%b", tag, k, dout, b); else n_pass++;
         n_chk++; if (done !== last) $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done, last); else n_pass++;
         n_chk++; if (ready !== last) $display("FAIL %s ready k=%0d got=%b exp=%b", tag, k, ready, last); else n_pass++;
         if (k == 0) din = w2;
         if (k == FL) load = 1'b0;
      end
      @(negedge clk);
      n_chk++; if (dout_vld !== 1'b0) $display("FAIL %s idle_vld got=%b exp=0", tag, dout_vld); else n_pass++;
      n_chk++; if (rx_q !== rx_exp) $display("FAIL %s loopback got=%h exp=%h", tag, rx_q, rx_exp); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      logic [W-1:0] w;
      logic b;
      w = W'($urandom);
      @(negedge clk);
      load = 1'b1; din = w;
      push_frame(w);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         load = 1'b0;
         b = exp_q.pop_front();
         n_chk++; if (dout !== b) $display("FAIL midrst dout k=%0d got=%b exp=%b", k, dout, b); else n_pass++;
      end
      #2 clr_n = 1'b0;
      #1;
      n_chk++; if (dout !== 1'b0) $display("FAIL midrst_dout got=%b exp=0", dout); else n_pass++;
      n_chk++; if (dout_vld !== 1'b0) $display("FAIL midrst_vld got=%b exp=0", dout_vld); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done); else n_pass++;
      n_chk++; if (ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", ready); else n_pass++;
      exp_q.delete();
      rx_exp = '0;
      @(negedge clk);
      clr_n = 1'b1;
      send_frame(8'h81, -1, '0, "after_rst_81");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         send_frame(W'($urandom), -1, '0, "rand");
      for (int i = 0; i < 4; i++)
         send_frame(W'($urandom), $urandom_range(0, FL - 2), W'($urandom), "rand_poke");
      for (int i = 0; i < 3; i++)
         test_back_to_back(W'($urandom), W'($urandom), "rand_b2b");
   endtask

   initial begin
      test_reset();
      send_frame(8'hA5, -1, '0, "basic_a5");
      send_frame(8'h3C, -1, '0, "loop_3c");
      test_back_to_back(8'hA5, 8'h3C, "b2b_a5_3c");
      send_frame(8'h00, 2, 8'hFF, "ignore_ff");
      test_reset_mid_frame();
`ifdef PISO_PARITY_EN
      send_frame(8'hA5, -1, '0, "parity_a5");
      send_frame(8'h07, -1, '0, "parity_07");
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
